// File: rtl/fidus_axi4lite_pkg.sv
// Shared AXI4-Lite slave definitions: response codes, channel FSM states and
// the byte-strobe merge helper used when committing a write.
package fidus_axi4lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Widest data bus the merge helper handles; callers zero-extend and truncate.
   localparam int MAX_DW   = 64;
   localparam int MAX_STRB = MAX_DW / 8;

   typedef enum logic [2:0] {
      WR_IDLE,
      WR_HAVE_AW,
      WR_HAVE_W,
      WR_BOTH,
      WR_RESP
   } wr_state_t;

   typedef enum logic {
      RD_IDLE,
      RD_RESP
   } rd_state_t;

   // Replace byte k of i_old with byte k of i_new wherever i_strb[k] is set.
   function automatic logic [MAX_DW-1:0] fStrbMerge(input logic [MAX_DW-1:0]   i_old,
                                                    input logic [MAX_DW-1:0]   i_new,
                                                    input logic [MAX_STRB-1:0] i_strb);
      logic [MAX_DW-1:0] v;
      v = i_old;
      for (int k = 0; k < MAX_STRB; k++) begin
         if (i_strb[k]) v[8*k +: 8] = i_new[8*k +: 8];
      end
      return v;
   endfunction

endpackage

// File: rtl/fidus_axi4lite_slv_regfile.sv
// AXI4-Lite slave register file. Word 0 is a read-only ID; the remaining words
// are read/write with byte strobes. Writes commit one edge after both AW and W
// have been captured; reads sample the array before a same-edge commit.
module fidus_axi4lite_slv_regfile
   import fidus_axi4lite_pkg::*;
#(
   parameter int          AWIDTH   = 8,
   parameter int          DWIDTH   = 16,
   parameter int          NUM_REGS = 16,
   parameter logic [63:0] ID_VALUE = 64'hF1D5
) (
   input  logic                         aclk,
   input  logic                         areset,
   input  logic [AWIDTH-1:0]            awaddr,
   input  logic                         awvalid,
   output logic                         awready,
   input  logic [DWIDTH-1:0]            wdata,
   input  logic [DWIDTH/8-1:0]          wstrb,
   input  logic                         wvalid,
   output logic                         wready,
   output logic [1:0]                   bresp,
   output logic                         bvalid,
   input  logic                         bready,
   input  logic [AWIDTH-1:0]            araddr,
   input  logic                         arvalid,
   output logic                         arready,
   output logic [DWIDTH-1:0]            rdata,
   output logic [1:0]                   rresp,
   output logic                         rvalid,
   input  logic                         rready,
   output logic [NUM_REGS*DWIDTH-1:0]   o_regs,
   output logic [NUM_REGS-1:0]          o_wr_pulse
);

   localparam int                ADDR_LSB = $clog2(DWIDTH / 8);
   localparam int                RIDX_W   = $clog2(NUM_REGS);
   localparam logic [DWIDTH-1:0] ID_W     = ID_VALUE[DWIDTH-1:0];

   wr_state_t               r_wr_state, w_wr_next;
   rd_state_t               r_rd_state, w_rd_next;
   logic [AWIDTH-1:0]       r_awaddr;
   logic [DWIDTH-1:0]       r_wdata;
   logic [DWIDTH/8-1:0]     r_wstrb;
   logic [1:0]              r_bresp;
   logic [NUM_REGS-1:0]     r_wr_pulse;
   logic [DWIDTH-1:0]       r_rdata;
   logic [1:0]              r_rresp;

   logic [DWIDTH-1:0]       w_words [NUM_REGS];
   logic [RIDX_W-1:0]       w_widx, w_ridx;
   logic                    w_wslverr, w_rslverr, w_commit;
   logic [DWIDTH-1:0]       w_merged;

   // Address decode: byte-lane bits dropped, anything above the array is an error.
   assign w_widx    = r_awaddr[ADDR_LSB +: RIDX_W];
   assign w_wslverr = ((r_awaddr >> (ADDR_LSB + RIDX_W)) != '0) || (w_widx == '0);
   assign w_ridx    = araddr[ADDR_LSB +: RIDX_W];
   assign w_rslverr = (araddr >> (ADDR_LSB + RIDX_W)) != '0;

   assign w_commit  = (r_wr_state == WR_BOTH) && !w_wslverr;
   assign w_merged  = DWIDTH'(fStrbMerge(MAX_DW'(w_words[w_widx]), MAX_DW'(r_wdata),
                                         MAX_STRB'(r_wstrb)));

   assign awready    = (r_wr_state == WR_IDLE) || (r_wr_state == WR_HAVE_W);
   assign wready     = (r_wr_state == WR_IDLE) || (r_wr_state == WR_HAVE_AW);
   assign bvalid     = (r_wr_state == WR_RESP);
   assign bresp      = r_bresp;
   assign arready    = (r_rd_state == RD_IDLE);
   assign rvalid     = (r_rd_state == RD_RESP);
   assign rdata      = r_rdata;
   assign rresp      = r_rresp;
   assign o_wr_pulse = r_wr_pulse;

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_id
         assign w_words[gi] = ID_W;
      end else begin : g_rw
         logic [DWIDTH-1:0] r_word;
         // Word gi: cleared by reset, strobe-merged when a write to it commits.
         always_ff @(posedge aclk) begin
            if (areset)                                  r_word <= '0;
            else if (w_commit && (w_widx == RIDX_W'(gi))) r_word <= w_merged;
         end
         assign w_words[gi] = r_word;
      end
      assign o_regs[gi*DWIDTH +: DWIDTH] = w_words[gi];
   end

   // Write channel next state: collect AW and W in any order, then commit, then B.
   always_comb begin
      w_wr_next = r_wr_state;
      case (r_wr_state)
         WR_IDLE: begin
            if (awvalid && wvalid) w_wr_next = WR_BOTH;
            else if (awvalid)      w_wr_next = WR_HAVE_AW;
            else if (wvalid)       w_wr_next = WR_HAVE_W;
         end
         WR_HAVE_AW: if (wvalid)  w_wr_next = WR_BOTH;
         WR_HAVE_W:  if (awvalid) w_wr_next = WR_BOTH;
         WR_BOTH:                 w_wr_next = WR_RESP;
         WR_RESP:    if (bready)  w_wr_next = WR_IDLE;
         default:                 w_wr_next = WR_IDLE;
      endcase
   end

   // Write channel state, captured AW/W, response code and commit pulse.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_wr_state <= WR_IDLE;
         r_awaddr   <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_bresp    <= RESP_OKAY;
         r_wr_pulse <= '0;
      end else begin
         r_wr_state <= w_wr_next;
         r_wr_pulse <= '0;
         if (awvalid && awready) r_awaddr <= awaddr;
         if (wvalid && wready) begin
            r_wdata <= wdata;
            r_wstrb <= wstrb;
         end
         if (r_wr_state == WR_BOTH) begin
            r_bresp <= w_wslverr ? RESP_SLVERR : RESP_OKAY;
            if (!w_wslverr && (r_wstrb != '0)) r_wr_pulse[w_widx] <= 1'b1;
         end else if (bvalid && bready) begin
            r_bresp <= RESP_OKAY;
         end
      end
   end

   // Read channel next state: one outstanding read, held until accepted.
   always_comb begin
      w_rd_next = r_rd_state;
      case (r_rd_state)
         RD_IDLE: if (arvalid) w_rd_next = RD_RESP;
         RD_RESP: if (rready)  w_rd_next = RD_IDLE;
         default:              w_rd_next = RD_IDLE;
      endcase
   end

   // Read channel state and response data; rdata is zero whenever R is idle.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_rd_state <= RD_IDLE;
         r_rdata    <= '0;
         r_rresp    <= RESP_OKAY;
      end else begin
         r_rd_state <= w_rd_next;
         if (arvalid && arready) begin
            r_rdata <= w_rslverr ? '0 : w_words[w_ridx];
            r_rresp <= w_rslverr ? RESP_SLVERR : RESP_OKAY;
         end else if (rvalid && rready) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
         end
      end
   end

endmodule

// File: tb/tb_fidus_axi4lite_slv_regfile.sv
// Directed bench for the AXI4-Lite slave register file: a vector table of
// single transactions plus hand-timed sequences for ordering, backpressure
// and reset abort.
module tb_fidus_axi4lite_slv_regfile;

   logic         aclk = 1'b0;
   logic         areset;
   logic [7:0]   awaddr, araddr;
   logic         awvalid, wvalid, bready, arvalid, rready;
   logic [15:0]  wdata;
   logic [1:0]   wstrb;
   logic         awready, wready, bvalid, arready, rvalid;
   logic [1:0]   bresp, rresp;
   logic [15:0]  rdata;
   logic [255:0] o_regs;
   logic [15:0]  o_wr_pulse;

   int n_chk = 0;
   int n_err = 0;
   int pulse_cnt [16];

   fidus_axi4lite_slv_regfile #(.AWIDTH(8), .DWIDTH(16), .NUM_REGS(16), .ID_VALUE(64'hF1D5)) dut (
      .aclk(aclk), .areset(areset),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .o_regs(o_regs), .o_wr_pulse(o_wr_pulse)
   );

   always #5 aclk = ~aclk;

   // Count commit pulses per register, sampled mid-cycle.
   always @(negedge aclk) begin
      for (int i = 0; i < 16; i++) pulse_cnt[i] <= pulse_cnt[i] + int'(o_wr_pulse[i]);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog act=running req=finished");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit          is_wr;
      logic [7:0]  addr;
      logic [15:0] data;
      logic [1:0]  strb;
      logic [1:0]  exp_resp;
      logic [15:0] exp_rdata;
      int          exp_pulse;
   } vec_t;

   vec_t vecs [19];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%h req=%h", name, act, exp);
      end
   endtask

   function automatic int pulse_sum();
      int s = 0;
      for (int i = 0; i < 16; i++) s += pulse_cnt[i];
      return s;
   endfunction

   // Full write transaction; called at a negedge.
   task automatic do_write(input logic [7:0] a, input logic [15:0] d, input logic [1:0] s,
                           output logic [1:0] resp);
      bit a_hs, w_hs;
      int n;
      awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
      n = 0;
      while ((awvalid || wvalid) && n < 50) begin
         a_hs = awvalid && awready;
         w_hs = wvalid && wready;
         @(negedge aclk);
         if (a_hs) awvalid = 1'b0;
         if (w_hs) wvalid = 1'b0;
         n++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      bready = 1'b1; n = 0;
      while (!bvalid && n < 50) begin
         @(negedge aclk);
         n++;
      end
      chk("wr_bvalid_seen", {255'd0, bvalid}, 256'd1);
      resp = bresp;
      @(negedge aclk);
      bready = 1'b0;
   endtask

   // Full read transaction; called at a negedge.
   task automatic do_read(input logic [7:0] a, output logic [1:0] resp, output logic [15:0] d);
      int n;
      araddr = a; arvalid = 1'b1; n = 0;
      while (!arready && n < 50) begin
         @(negedge aclk);
         n++;
      end
      @(negedge aclk);
      arvalid = 1'b0;
      rready = 1'b1; n = 0;
      while (!rvalid && n < 50) begin
         @(negedge aclk);
         n++;
      end
      chk("rd_rvalid_seen", {255'd0, rvalid}, 256'd1);
      resp = rresp;
      d = rdata;
      @(negedge aclk);
      rready = 1'b0;
   endtask

   initial begin
      logic [1:0]   resp;
      logic [15:0]  d;
      logic [255:0] exp_regs;
      int           snap [16];
      int           tot0;
      bit           stable;

      vecs[0]  = '{1'b1, 8'h0E, 16'hABAB, 2'b11, 2'b00, 16'h0000, 7};
      vecs[1]  = '{1'b0, 8'h0E, 16'h0000, 2'b00, 2'b00, 16'hABAB, -1};
      vecs[2]  = '{1'b1, 8'h0F, 16'h1234, 2'b11, 2'b00, 16'h0000, 7};
      vecs[3]  = '{1'b0, 8'h0E, 16'h0000, 2'b00, 2'b00, 16'h1234, -1};
      vecs[4]  = '{1'b1, 8'h0E, 16'hFF00, 2'b10, 2'b00, 16'h0000, 7};
      vecs[5]  = '{1'b0, 8'h0F, 16'h0000, 2'b00, 2'b00, 16'hFF34, -1};
      vecs[6]  = '{1'b0, 8'hAA, 16'h0000, 2'b00, 2'b10, 16'h0000, -1};
      vecs[7]  = '{1'b1, 8'hAA, 16'h5555, 2'b11, 2'b10, 16'h0000, -1};
      vecs[8]  = '{1'b0, 8'h00, 16'h0000, 2'b00, 2'b00, 16'hF1D5, -1};
      vecs[9]  = '{1'b1, 8'h01, 16'hFFFF, 2'b11, 2'b10, 16'h0000, -1};
      vecs[10] = '{1'b0, 8'h01, 16'h0000, 2'b00, 2'b00, 16'hF1D5, -1};
      vecs[11] = '{1'b1, 8'h04, 16'h00FF, 2'b00, 2'b00, 16'h0000, -1};
      vecs[12] = '{1'b0, 8'h04, 16'h0000, 2'b00, 2'b00, 16'h0000, -1};
      vecs[13] = '{1'b1, 8'h04, 16'hA5C3, 2'b01, 2'b00, 16'h0000, 2};
      vecs[14] = '{1'b0, 8'h05, 16'h0000, 2'b00, 2'b00, 16'h00C3, -1};
      vecs[15] = '{1'b1, 8'h1E, 16'h7E81, 2'b11, 2'b00, 16'h0000, 15};
      vecs[16] = '{1'b0, 8'h1F, 16'h0000, 2'b00, 2'b00, 16'h7E81, -1};
      vecs[17] = '{1'b0, 8'h20, 16'h0000, 2'b00, 2'b10, 16'h0000, -1};
      vecs[18] = '{1'b1, 8'h20, 16'h1111, 2'b11, 2'b10, 16'h0000, -1};

      areset = 1'b1; awaddr = '0; araddr = '0; awvalid = 0; wvalid = 0;
      bready = 0; arvalid = 0; rready = 0; wdata = '0; wstrb = '0;
      repeat (3) @(negedge aclk);
      areset = 1'b0;
      @(negedge aclk);

      // Reset state
      exp_regs = '0; exp_regs[15:0] = 16'hF1D5;
      chk("rst_regs", o_regs, exp_regs);
      chk("rst_valids", {253'd0, bvalid, rvalid, o_wr_pulse != 16'd0}, 256'd0);
      chk("rst_readies", {253'd0, awready, wready, arready}, 256'd7);
      chk("rst_rdata", rdata, 256'd0);
      chk("rst_resps", {bresp, rresp}, 256'd0);

      // Vector table
      for (int i = 0; i < 19; i++) begin
         snap = pulse_cnt;
         tot0 = pulse_sum();
         if (vecs[i].is_wr) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
            chk($sformatf("v%0d_bresp", i), resp, vecs[i].exp_resp);
            chk($sformatf("v%0d_npulse", i), pulse_sum() - tot0, (vecs[i].exp_pulse >= 0) ? 1 : 0);
            if (vecs[i].exp_pulse >= 0)
               chk($sformatf("v%0d_pulse_bit", i),
                   pulse_cnt[vecs[i].exp_pulse] - snap[vecs[i].exp_pulse], 256'd1);
         end else begin
            do_read(vecs[i].addr, resp, d);
            chk($sformatf("v%0d_rresp", i), resp, vecs[i].exp_resp);
            chk($sformatf("v%0d_rdata", i), d, vecs[i].exp_rdata);
         end
      end
      exp_regs = '0;
      exp_regs[0*16 +: 16]  = 16'hF1D5;
      exp_regs[2*16 +: 16]  = 16'h00C3;
      exp_regs[7*16 +: 16]  = 16'hFF34;
      exp_regs[15*16 +: 16] = 16'h7E81;
      chk("table_regs", o_regs, exp_regs);

      // W three cycles ahead of AW, to reg 3
      wdata = 16'h3C3C; wstrb = 2'b11; wvalid = 1'b1;
      @(negedge aclk);
      wvalid = 1'b0;
      chk("wfirst_readies", {254'd0, awready, wready}, 256'd2);
      repeat (2) @(negedge aclk);
      awaddr = 8'h06; awvalid = 1'b1;
      @(negedge aclk);
      awvalid = 1'b0;
      chk("wfirst_bvalid_N", bvalid, 256'd0);
      @(negedge aclk);
      chk("wfirst_bvalid_N1", bvalid, 256'd1);
      chk("wfirst_pulse", o_wr_pulse, 256'h0008);
      chk("wfirst_word", o_regs[3*16 +: 16], 256'h3C3C);
      bready = 1'b1;
      @(negedge aclk);
      bready = 1'b0;
      chk("wfirst_bdone", bvalid, 256'd0);

      // AW and W in the same cycle, to reg 4
      awaddr = 8'h08; awvalid = 1'b1; wdata = 16'h4D4D; wstrb = 2'b11; wvalid = 1'b1;
      @(negedge aclk);
      awvalid = 1'b0; wvalid = 1'b0;
      chk("same_state_N", {253'd0, bvalid, awready, wready}, 256'd0);
      @(negedge aclk);
      chk("same_bvalid_N1", {254'd0, bvalid, bresp == 2'b00}, 256'd3);
      chk("same_pulse", o_wr_pulse, 256'h0010);
      bready = 1'b1;
      @(negedge aclk);
      bready = 1'b0;
      chk("same_word", o_regs[4*16 +: 16], 256'h4D4D);

      // Read on the commit edge of a write to the same word returns the old value
      awaddr = 8'h0C; awvalid = 1'b1; wdata = 16'h1357; wstrb = 2'b11; wvalid = 1'b1;
      @(negedge aclk);
      awvalid = 1'b0; wvalid = 1'b0;
      araddr = 8'h0C; arvalid = 1'b1;
      @(negedge aclk);
      arvalid = 1'b0;
      chk("race_rdata_old", {239'd0, rvalid, rdata}, {239'd0, 1'b1, 16'h0000});
      bready = 1'b1; rready = 1'b1;
      @(negedge aclk);
      bready = 1'b0; rready = 1'b0;
      chk("race_idle", {238'd0, bvalid, rvalid, rdata}, 256'd0);
      do_read(8'h0C, resp, d);
      chk("race_rdata_new", d, 256'h1357);

      // Backpressure on B and R for 10 cycles
      snap = pulse_cnt;
      awaddr = 8'h0A; awvalid = 1'b1; wdata = 16'h0BAD; wstrb = 2'b11; wvalid = 1'b1;
      araddr = 8'h0E; arvalid = 1'b1;
      @(negedge aclk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      stable = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge aclk);
         if (!(bvalid && rvalid && !awready && !wready && !arready &&
               rdata == 16'hFF34 && bresp == 2'b00 && rresp == 2'b00)) stable = 1'b0;
      end
      chk("bp_stable", {255'd0, stable}, 256'd1);
      bready = 1'b1; rready = 1'b1;
      @(negedge aclk);
      bready = 1'b0; rready = 1'b0;
      chk("bp_release", {238'd0, bvalid, rvalid, rdata}, 256'd0);
      chk("bp_readies", {253'd0, awready, wready, arready}, 256'd7);
      chk("bp_single_pulse", pulse_cnt[5] - snap[5], 256'd1);
      chk("bp_word", o_regs[5*16 +: 16], 256'h0BAD);

      // Reset on the commit edge aborts the write
      snap = pulse_cnt;
      awaddr = 8'h12; awvalid = 1'b1; wdata = 16'h9999; wstrb = 2'b11; wvalid = 1'b1;
      @(negedge aclk);
      awvalid = 1'b0; wvalid = 1'b0; areset = 1'b1;
      @(negedge aclk);
      areset = 1'b0;
      chk("abort_bvalid", bvalid, 256'd0);
      chk("abort_word", o_regs[9*16 +: 16], 256'd0);
      chk("abort_pulse", pulse_cnt[9] - snap[9], 256'd0);

      // Reset with B pending and an AR waiting behind an unaccepted R
      do_write(8'h02, 16'h2222, 2'b11, resp);
      araddr = 8'h0E; arvalid = 1'b1;
      @(negedge aclk);
      arvalid = 1'b0;
      awaddr = 8'h14; awvalid = 1'b1; wdata = 16'hAAAA; wstrb = 2'b11; wvalid = 1'b1;
      @(negedge aclk);
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge aclk);
      chk("pre_rst_pending", {254'd0, bvalid, rvalid}, 256'd3);
      araddr = 8'h02; arvalid = 1'b1;
      @(negedge aclk);
      areset = 1'b1;
      @(negedge aclk);
      areset = 1'b0; arvalid = 1'b0;
      exp_regs = '0; exp_regs[15:0] = 16'hF1D5;
      chk("mid_rst_valids", {254'd0, bvalid, rvalid}, 256'd0);
      chk("mid_rst_regs", o_regs, exp_regs);
      chk("mid_rst_readies", {253'd0, awready, wready, arready}, 256'd7);
      chk("mid_rst_rdata", {rdata, bresp, rresp, o_wr_pulse}, 256'd0);

      // Normal operation after reset
      do_write(8'h02, 16'h4242, 2'b11, resp);
      chk("post_rst_bresp", resp, 256'd0);
      do_read(8'h02, resp, d);
      chk("post_rst_rdata", {resp, d}, {2'b00, 16'h4242});

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
